// File: rtl/std_cache_pkg.sv
// Shared data-cache types: flush-walk state encoding and walk mode.
// Latency: n/a (types only).
// Backpressure: n/a.
package std_cache_pkg;

    // Flush/init walk states. ACK is only reached from a flush walk.
    typedef enum logic [2:0] {
        IDLE,
        READ_SET,
        RDATA,
        SCAN,
        INVAL,
        DRAIN,
        ACK
    } dcache_flush_state_e;

    // A flush writes back dirty lines; an init walk only invalidates.
    typedef enum logic {
        MODE_FLUSH,
        MODE_INIT
    } flush_mode_e;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter; MODE=0 gives the index of the lowest set bit.
// Latency: combinational.
// Backpressure: n/a.
// Ports: in_i vector, cnt_o zero count (0 when empty), empty_o no bit set.
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o = '0;
        if (MODE == 1'b0) begin
            // Scan downwards so the lowest set bit is the last one written.
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(i);
            end
        end else begin
            // Scan upwards so the highest set bit wins; report zeros above it.
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/dcache_flush_unit.sv
// Walks every dcache set: writes back valid dirty lines, invalidates the set, acks when all write-backs done.
// Latency: 4 cycles per clean set with immediate grants, plus one per accepted write-back, plus DRAIN and ACK.
// Backpressure: tag requests held until tag_gnt_i; write-backs held until wb_ready_i and stalled at MAX_WB outstanding.
// Ports: flush_i/flush_ack_o and init_i from the controller, busy_o for its drain counter,
//        tag_* set read/invalidate port, wb_* write-back request port with wb_done_i completion pulses.
module dcache_flush_unit
    import std_cache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 256,
    parameter int unsigned NUM_WAYS = 8,
    parameter int unsigned TAG_W    = 44,
    parameter int unsigned MAX_WB   = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_SETS),
    localparam int unsigned WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int unsigned CNT_W   = $clog2(MAX_WB + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    output logic                      flush_ack_o,
    input  logic                      init_i,
    output logic                      busy_o,
    output logic                      tag_req_o,
    input  logic                      tag_gnt_i,
    output logic                      tag_we_o,
    output logic [IDX_W-1:0]          tag_idx_o,
    input  logic [NUM_WAYS-1:0]       tag_valid_i,
    input  logic [NUM_WAYS-1:0]       tag_dirty_i,
    input  logic [NUM_WAYS*TAG_W-1:0] tag_tags_i,
    output logic                      wb_valid_o,
    input  logic                      wb_ready_i,
    output logic [IDX_W-1:0]          wb_idx_o,
    output logic [WAY_W-1:0]          wb_way_o,
    output logic [TAG_W-1:0]          wb_tag_o,
    input  logic                      wb_done_i
);

    dcache_flush_state_e             state_q, state_d;
    flush_mode_e                     mode_q, mode_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic                            armed_q, armed_d;
    logic [CNT_W-1:0]                outstanding_q, outstanding_d;
    logic [NUM_WAYS-1:0]             mask_q, mask_d;
    logic [NUM_WAYS-1:0][TAG_W-1:0]  tags_q, tags_d;

    logic [WAY_W-1:0] way_sel;
    logic             mask_empty;
    logic             wb_room;
    logic             wb_fire;
    logic             done_eff;

    lzc #(
        .WIDTH    (NUM_WAYS),
        .MODE     (1'b0),
        .CNT_WIDTH(WAY_W)
    ) i_way_sel (
        .in_i   (mask_q),
        .cnt_o  (way_sel),
        .empty_o(mask_empty)
    );

    // ---------------- output decodes (registered state only) ----------------
    assign wb_room     = outstanding_q < CNT_W'(MAX_WB);
    assign wb_valid_o  = (state_q == SCAN) && !mask_empty && wb_room;
    assign wb_fire     = wb_valid_o && wb_ready_i;
    // Buses read zero whenever no request is presented.
    assign wb_idx_o    = wb_valid_o ? idx_q : '0;
    assign wb_way_o    = wb_valid_o ? way_sel : '0;
    assign wb_tag_o    = wb_valid_o ? tags_q[way_sel] : '0;

    assign tag_req_o   = (state_q == READ_SET) || (state_q == INVAL);
    assign tag_we_o    = (state_q == INVAL);
    assign tag_idx_o   = idx_q;
    assign flush_ack_o = (state_q == ACK);
    assign busy_o      = (state_q != IDLE) || (outstanding_q != '0);

    // ---------------- outstanding write-back counter ----------------
    // A completion with nothing outstanding is dropped so the count never wraps.
    assign done_eff = wb_done_i && (outstanding_q != '0);

    always_comb begin
        outstanding_d = outstanding_q;
        if (wb_fire && !done_eff) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!wb_fire && done_eff) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    // ---------------- walk FSM ----------------
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        tags_d  = tags_q;
        // Re-arm as soon as the request is seen low, so the request level
        // lingering one cycle after ack cannot start a second walk.
        armed_d = armed_q | ~flush_i;

        unique case (state_q)
            IDLE: begin
                if (flush_i && armed_q) begin
                    state_d = READ_SET;
                    mode_d  = MODE_FLUSH;
                    idx_d   = '0;
                    armed_d = 1'b0;
                end else if (init_i) begin
                    state_d = INVAL;
                    mode_d  = MODE_INIT;
                    idx_d   = '0;
                end
            end
            READ_SET: begin
                if (tag_gnt_i) state_d = RDATA;
            end
            RDATA: begin
                // Only lines that are both valid and dirty need writing back.
                mask_d  = tag_valid_i & tag_dirty_i;
                tags_d  = tag_tags_i;
                state_d = SCAN;
            end
            SCAN: begin
                if (mask_empty) begin
                    state_d = INVAL;
                end else if (wb_fire) begin
                    mask_d = mask_q & ~(NUM_WAYS'(1) << way_sel);
                end
            end
            INVAL: begin
                if (tag_gnt_i) begin
                    if (idx_q == IDX_W'(NUM_SETS - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = (mode_q == MODE_FLUSH) ? READ_SET : INVAL;
                    end
                end
            end
            DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = (mode_q == MODE_FLUSH) ? ACK : IDLE;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            mode_q        <= MODE_FLUSH;
            idx_q         <= '0;
            armed_q       <= 1'b1;
            outstanding_q <= '0;
            mask_q        <= '0;
            tags_q        <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            idx_q         <= idx_d;
            armed_q       <= armed_d;
            outstanding_q <= outstanding_d;
            mask_q        <= mask_d;
            tags_q        <= tags_d;
        end
    end

    // A completion pulse with no write-back outstanding is a protocol error upstream.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(wb_done_i && (outstanding_q == '0)));

endmodule
